// File: rtl/lvds_rx_align.sv
// lvds_rx_align: delay-tap sweep, eye centring, bit-order retry and link monitor for a 4-lane DDR LVDS receiver
module lvds_rx_align #(
    parameter int TAP_W   = 9,
    parameter int NTAPS   = 512,
    parameter int WINDOW  = 1024,
    parameter int SETTLE  = 16,
    parameter int MIN_EYE = 8,
    parameter int ERRC_W  = 16
) (
    input  logic              rxclk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    output logic [7:0]        rx_word,
    output logic [TAP_W-1:0]  dly_tap,
    output logic              dly_load,
    output logic              swap,
    output logic              busy,
    output logic              locked,
    output logic              fail,
    output logic [TAP_W-1:0]  eye_start,
    output logic [TAP_W:0]    eye_len,
    output logic [ERRC_W-1:0] err_count
);
    localparam int CMAX  = WINDOW > SETTLE ? WINDOW : SETTLE;
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_MEASURE, S_EVAL, S_DECIDE, S_LOAD_FINAL, S_MONITOR
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        prev_word, swapped;
    logic              tap_err, final_pass;
    logic [TAP_W-1:0]  run_start, best_start, clean_start;
    logic [TAP_W:0]    run_len, best_len, clean_len;
    logic              good, settle_done, window_done, eye_ok, last_tap, restart;

    assign swapped     = {rx_data[6], rx_data[7], rx_data[4], rx_data[5],
                          rx_data[2], rx_data[3], rx_data[0], rx_data[1]};
    assign good        = rx_word == prev_word + 8'd1;
    assign settle_done = cnt == CNT_W'(SETTLE - 1);
    assign window_done = cnt == CNT_W'(WINDOW);
    assign eye_ok      = best_len >= (TAP_W+1)'(MIN_EYE);
    assign last_tap    = dly_tap == TAP_W'(NTAPS - 1);
    assign clean_len   = run_len + (TAP_W+1)'(1);
    assign clean_start = run_len == '0 ? dly_tap : run_start;
    assign restart     = start && (state == S_IDLE || state == S_MONITOR);

    // State register
    always_ff @(posedge rxclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode plus the state-derived strobes
    always_comb begin
        state_d  = state;
        dly_load = state == S_LOAD || state == S_LOAD_FINAL;
        busy     = state != S_IDLE && state != S_MONITOR;
        case (state)
            S_IDLE:       state_d = start ? S_LOAD : S_IDLE;
            S_LOAD:       state_d = S_SETTLE;
            S_LOAD_FINAL: state_d = S_SETTLE;
            S_SETTLE:     state_d = settle_done ? (final_pass ? S_MONITOR : S_MEASURE) : S_SETTLE;
            S_MEASURE:    state_d = window_done ? S_EVAL : S_MEASURE;
            S_EVAL:       state_d = last_tap ? S_DECIDE : S_LOAD;
            S_DECIDE:     state_d = eye_ok ? S_LOAD_FINAL : (swap ? S_IDLE : S_LOAD);
            S_MONITOR:    state_d = start ? S_LOAD : S_MONITOR;
            default:      state_d = S_IDLE;
        endcase
    end

    // Datapath: word capture, tap scoring, run tracking, centring and post-lock monitoring.
    // The expected word free-runs from the first captured word so one corrupt word counts once.
    always_ff @(posedge rxclk) begin
        if (rst) begin
            rx_word    <= '0;
            dly_tap    <= '0;
            swap       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            eye_start  <= '0;
            eye_len    <= '0;
            err_count  <= '0;
            cnt        <= '0;
            prev_word  <= '0;
            tap_err    <= 1'b0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            final_pass <= 1'b0;
        end else begin
            rx_word <= swap ? swapped : rx_data;
            if (restart) begin
                dly_tap    <= '0;
                swap       <= 1'b0;
                fail       <= 1'b0;
                locked     <= 1'b0;
                err_count  <= '0;
                eye_start  <= '0;
                eye_len    <= '0;
                run_start  <= '0;
                run_len    <= '0;
                best_start <= '0;
                best_len   <= '0;
                final_pass <= 1'b0;
            end
            case (state)
                S_LOAD, S_LOAD_FINAL: cnt <= '0;
                S_SETTLE: cnt <= settle_done ? '0 : cnt + CNT_W'(1);
                S_MEASURE: begin
                    cnt       <= window_done ? '0 : cnt + CNT_W'(1);
                    prev_word <= cnt == '0 ? rx_word : prev_word + 8'd1;
                    tap_err   <= cnt == '0 ? 1'b0 : tap_err | ~good;
                end
                S_EVAL: begin
                    run_len   <= tap_err ? '0 : clean_len;
                    run_start <= clean_start;
                    if (!tap_err && clean_len > best_len) begin
                        best_start <= clean_start;
                        best_len   <= clean_len;
                    end
                    if (!last_tap) dly_tap <= dly_tap + TAP_W'(1);
                end
                S_DECIDE: begin
                    if (eye_ok) begin
                        dly_tap    <= best_start + TAP_W'(best_len >> 1);
                        eye_start  <= best_start;
                        eye_len    <= best_len;
                        final_pass <= 1'b1;
                    end else if (!swap) begin
                        swap       <= 1'b1;
                        dly_tap    <= '0;
                        run_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                    end else begin
                        fail <= 1'b1;
                        swap <= 1'b0;
                    end
                end
                S_MONITOR: begin
                    if (!start) begin
                        cnt       <= CNT_W'(1);
                        prev_word <= cnt == '0 ? rx_word : prev_word + 8'd1;
                        if (cnt != '0) begin
                            locked <= good;
                            if (!good && err_count != '1) err_count <= err_count + ERRC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
